gmac_tx_arbiter: RTL



---
 rtl/gmac_arb_pkg.sv | 16 +
 rtl/gmac_tx_arbiter_rr_pick.sv | 36 +++
 rtl/gmac_tx_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/gmac_arb_pkg.sv
// Shared types and defaults for the GMAC TX arbiter.
// Holds the FSM state encoding and default timing constants.
// No logic; imported by the arbiter and its round-robin selector.
package gmac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam int IFG_DEFAULT     = 12;
  localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/gmac_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Zero latency; searches from last_sel+1 upward, wrapping to 0.
// No backpressure; 'any' flags that at least one request is pending.
module rr_pick
  import gmac_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last_sel,
  output logic [SW-1:0] sel,
  output logic          any
);

  logic found_hi;

  // Lowest requester above last_sel wins; otherwise lowest requester overall.
  always_comb begin
    sel      = last_sel;
    found_hi = 1'b0;
    any      = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(last_sel))) begin
        sel      = SW'(i);
        found_hi = 1'b1;
      end
    end
    if (!found_hi) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/gmac_tx_arbiter.sv
// gmac_tx_arbiter: shares one GMAC TX channel among NUM_REQ frame sources.
// Latency: selected source's bytes/strobes reach the GMAC 1 cycle after input.
// Backpressure: sources wait on gnt_o; GMAC paces us via mac_confirm_i. Stall
// timeout is built only with GMAC_ARB_TIMEOUT_EN defined.
module gmac_tx_arbiter
  import gmac_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int IFG_CYCLES     = IFG_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                 clk125,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   val_i,
  input  logic [NUM_REQ-1:0]   sof_i,
  input  logic [NUM_REQ-1:0]   eof_i,
  input  logic [8*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic                 mac_req_o,
  input  logic                 mac_confirm_i,
  output logic                 mac_val_o,
  output logic                 mac_sof_o,
  output logic                 mac_eof_o,
  output logic [7:0]           mac_data_o,
  output logic                 busy_o,
  output logic [15:0]          timeout_cnt_o
);

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t    state;
  logic [SW-1:0] sel;
  logic [SW-1:0] last_sel;
  logic [SW-1:0] pick_sel;
  logic          pick_any;
  logic [7:0]    gap_cnt;
  logic          val_sel;
  logic          sof_sel;
  logic          eof_sel;
  logic [7:0]    data_sel;
  logic          stall_hit;

  rr_pick #(.N(NUM_REQ), .SW(SW)) u_pick (
    .req      (req_i),
    .last_sel (last_sel),
    .sel      (pick_sel),
    .any      (pick_any)
  );

  assign val_sel  = val_i[sel];
  assign sof_sel  = sof_i[sel];
  assign eof_sel  = eof_i[sel];
  assign data_sel = data_i[{sel, 3'b000} +: 8];
  assign busy_o   = (state != IDLE);

  // Main FSM. GAP holds IFG_CYCLES+1 cycles: the first carries the registered
  // eof byte, the remaining IFG_CYCLES are fully quiet on the GMAC side.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      last_sel   <= SW'(NUM_REQ - 1);
      gnt_o      <= '0;
      mac_req_o  <= 1'b0;
      mac_val_o  <= 1'b0;
      mac_sof_o  <= 1'b0;
      mac_eof_o  <= 1'b0;
      mac_data_o <= 8'h00;
      gap_cnt    <= 8'h00;
    end else begin
      mac_val_o  <= 1'b0;
      mac_sof_o  <= 1'b0;
      mac_eof_o  <= 1'b0;
      mac_data_o <= 8'h00;
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel       <= pick_sel;
            mac_req_o <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (!req_i[sel]) begin
            // Source withdrew before the GMAC confirmed.
            mac_req_o <= 1'b0;
            last_sel  <= sel;
            state     <= IDLE;
          end else if (mac_confirm_i) begin
            mac_req_o <= 1'b0;
            gnt_o     <= NUM_REQ'(1) << sel;
            last_sel  <= sel;
            state     <= XFER;
          end else if (stall_hit) begin
            mac_req_o <= 1'b0;
            last_sel  <= sel;
            state     <= IDLE;
          end
        end
        XFER: begin
          mac_val_o  <= val_sel;
          mac_sof_o  <= val_sel & sof_sel;
          mac_eof_o  <= val_sel & eof_sel;
          mac_data_o <= val_sel ? data_sel : 8'h00;
          if (val_sel && eof_sel) begin
            gnt_o   <= '0;
            gap_cnt <= 8'h00;
            state   <= GAP;
          end else if (stall_hit) begin
            // Close the stalled frame with a synthetic empty eof byte.
            mac_val_o  <= 1'b1;
            mac_eof_o  <= 1'b1;
            mac_data_o <= 8'h00;
            gnt_o      <= '0;
            gap_cnt    <= 8'h00;
            state      <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(IFG_CYCLES)) state <= IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GMAC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stall_cnt;
  logic          stall_cond;

  assign stall_cond = ((state == REQ) && req_i[sel] && !mac_confirm_i) ||
                      ((state == XFER) && !val_sel);
  assign stall_hit  = stall_cond && (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled cycles; any progress or a timeout restarts it.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (stall_cond && !stall_hit) stall_cnt <= stall_cnt + 1'b1;
    else stall_cnt <= '0;
  end

  // Saturating count of aborted transactions.
  always_ff @(posedge clk125 or posedge rst) begin
    if (rst) timeout_cnt_o <= 16'h0000;
    else if (stall_hit && (timeout_cnt_o != 16'hFFFF)) timeout_cnt_o <= timeout_cnt_o + 16'd1;
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign stall_hit             = 1'b0;
  assign timeout_cnt_o         = 16'h0000;
`endif

endmodule
